m68k_bus_target: RTL and testbench

//  68000 asynchronous-bus responder: the target end of the cycles the PiStorm bus master generates.

---
 rtl/pistorm_pkg.sv | 17 +
 rtl/pistorm_sync2.sv | 27 ++
 rtl/m68k_bus_target.sv | 188 ++++++++++++++++++
 tb/tb_m68k_bus_target.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pistorm_pkg.sv
// Shared state encoding and bus-width constants for the PiStorm 68000 bus target.
package pistorm_pkg;

  localparam int ADDR_W     = 23;
  localparam int DATA_W     = 16;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    DSWAIT,
    REQ,
    SETUP,
    ACK
  } state_e;

endpackage

// File: rtl/pistorm_sync2.sv
// Multi-flop synchroniser for a vector of asynchronous, independently sampled bus strobes.
module pistorm_sync2
  import pistorm_pkg::*;
#(
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [SYNC_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 async-bus target: decodes a window and forwards each hit as one local req/ack access.
// Optional bus-error timeout is enabled by defining M68K_TARGET_BERR_EN.
module m68k_bus_target
  import pistorm_pkg::*;
#(
  parameter logic [23:0] ADDR_BASE  = 24'h200000,
  parameter logic [23:0] ADDR_MASK  = 24'hE00000,
  parameter int unsigned DATA_SETUP = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              c200m,
  input  logic              rst,
  input  logic              m68k_as_n,
  input  logic              m68k_uds_n,
  input  logic              m68k_lds_n,
  input  logic              m68k_rw,
  input  logic [ADDR_W-1:0] m68k_addr,
  input  logic [DATA_W-1:0] m68k_d_in,
  output logic [DATA_W-1:0] m68k_d_out,
  output logic              m68k_d_oe,
  output logic              dtack_oe,
  output logic              berr_oe,
  output logic              loc_req,
  output logic              loc_we,
  output logic [1:0]        loc_be,
  output logic [ADDR_W-1:0] loc_addr,
  output logic [DATA_W-1:0] loc_wdata,
  input  logic [DATA_W-1:0] loc_rdata,
  input  logic              loc_ack
);

  localparam logic [3:0] SETUP_LAST = 4'(DATA_SETUP - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  logic [3:0] sync_s;
  logic       as_s, rw_s;
  logic [1:0] ds_s;
  logic       hit;

  // Strobes reset to their released level so reset never looks like a bus cycle.
  pistorm_sync2 #(.W(4), .RST_VAL(4'hF)) u_sync (
    .clk_i (c200m),
    .rst_i (rst),
    .d_i   ({m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw}),
    .q_o   (sync_s)
  );

  assign {as_s, ds_s, rw_s} = {sync_s[3], sync_s[2:1], sync_s[0]};
  assign hit = (({m68k_addr, 1'b0} & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

  state_e              state_q, state_d;
  logic                req_q, req_d, we_q, we_d, doe_q, doe_d;
  logic                dtack_q, dtack_d, berr_q, berr_d, abort_q, abort_d;
  logic [1:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, dout_q, dout_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [3:0]          set_q, set_d;

  always_ff @(posedge c200m) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      doe_q   <= 1'b0;
      dtack_q <= 1'b0;
      berr_q  <= 1'b0;
      abort_q <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      tmo_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      doe_q   <= doe_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      abort_q <= abort_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      tmo_q   <= tmo_d;
      set_q   <= set_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    doe_d   = doe_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;
    abort_d = abort_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    tmo_d   = tmo_q;
    set_d   = set_q;
    unique case (state_q)
      IDLE:   if (!as_s) state_d = hit ? DSWAIT : MISS;
      MISS:   if (as_s) state_d = IDLE;
      DSWAIT: begin
        if (as_s) begin
          state_d = IDLE;
        end else if (ds_s != 2'b11) begin
          we_d    = !rw_s;
          be_d    = ~ds_s;
          addr_d  = m68k_addr;
          if (!rw_s) wdata_d = m68k_d_in;
          req_d   = 1'b1;
          tmo_d   = '0;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A master that gives up mid-request still sees the access finish, just unacknowledged.
        if (as_s) abort_d = 1'b1;
        if (loc_ack) begin
          req_d = 1'b0;
          if (abort_q || as_s) begin
            state_d = IDLE;
          end else if (!we_q) begin
            dout_d  = loc_rdata;
            doe_d   = 1'b1;
            set_d   = '0;
            state_d = SETUP;
          end else begin
            dtack_d = 1'b1;
            state_d = ACK;
          end
        end
`ifdef M68K_TARGET_BERR_EN
        else if (tmo_q == TMO_LAST) begin
          req_d = 1'b0;
          if (as_s) begin
            state_d = IDLE;
          end else begin
            berr_d  = 1'b1;
            state_d = ACK;
          end
        end
`endif
        else if (tmo_q != TMO_LAST) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      SETUP: begin
        if (as_s) begin
          doe_d   = 1'b0;
          state_d = IDLE;
        end else if (set_q == SETUP_LAST) begin
          dtack_d = 1'b1;
          state_d = ACK;
        end else begin
          set_d = set_q + 4'd1;
        end
      end
      ACK: begin
        if (as_s) begin
          dtack_d = 1'b0;
          doe_d   = 1'b0;
          berr_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m68k_d_out = dout_q;
  assign m68k_d_oe  = doe_q;
  assign dtack_oe   = dtack_q;
  assign berr_oe    = berr_q;
  assign loc_req    = req_q;
  assign loc_we     = we_q;
  assign loc_be     = be_q;
  assign loc_addr   = addr_q;
  assign loc_wdata  = wdata_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: table of bus transactions plus hand-written corner sequences.
module tb_m68k_bus_target;

  logic        c200m = 1'b0;
  logic        rst = 1'b1;
  logic        m68k_as_n = 1'b1, m68k_uds_n = 1'b1, m68k_lds_n = 1'b1, m68k_rw = 1'b1;
  logic [22:0] m68k_addr = '0;
  logic [15:0] m68k_d_in = '0;
  logic [15:0] m68k_d_out;
  logic        m68k_d_oe, dtack_oe, berr_oe, loc_req, loc_we;
  logic [1:0]  loc_be;
  logic [22:0] loc_addr;
  logic [15:0] loc_wdata;
  logic [15:0] loc_rdata = '0;
  logic        loc_ack = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  m68k_bus_target dut (
    .c200m(c200m), .rst(rst),
    .m68k_as_n(m68k_as_n), .m68k_uds_n(m68k_uds_n), .m68k_lds_n(m68k_lds_n), .m68k_rw(m68k_rw),
    .m68k_addr(m68k_addr), .m68k_d_in(m68k_d_in), .m68k_d_out(m68k_d_out), .m68k_d_oe(m68k_d_oe),
    .dtack_oe(dtack_oe), .berr_oe(berr_oe), .loc_req(loc_req), .loc_we(loc_we), .loc_be(loc_be),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata), .loc_ack(loc_ack)
  );

  always #5 c200m = ~c200m;
  always @(posedge c200m) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rw;
    logic [23:0] baddr;
    logic [1:0]  ds_n;
    logic [15:0] wdata;
    int          ack_dly;
    logic [15:0] rdata;
    logic        hit;
    logic [1:0]  be;
    logic [22:0] laddr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_cycle(input vec_t v);
    @(negedge c200m);
    m68k_addr = v.baddr[23:1];
    m68k_rw   = v.rw;
    m68k_as_n = 1'b0;
    m68k_d_in = v.rw ? 16'h0000 : v.wdata;
    // Writes assert the data strobes one 7 MHz clock (~28 c200m cycles) after AS.
    if (!v.rw) repeat (28) @(negedge c200m);
    {m68k_uds_n, m68k_lds_n} = v.ds_n;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      if (loc_req) break;
      @(negedge c200m);
    end
    chk("loc_req_seen", loc_req, 1'b1);
  endtask

  task automatic ack_pulse(input logic [15:0] rd);
    loc_rdata = rd;
    loc_ack   = 1'b1;
    @(negedge c200m);
    loc_ack   = 1'b0;
  endtask

  task automatic wait_dtack();
    for (int i = 0; i < 40; i++) begin
      if (dtack_oe) break;
      @(negedge c200m);
    end
  endtask

  task automatic release_bus();
    @(negedge c200m);
    m68k_as_n = 1'b1;
    {m68k_uds_n, m68k_lds_n} = 2'b11;
    repeat (3) @(negedge c200m);
    chk("release_dtack", dtack_oe, 1'b0);
    chk("release_doe", m68k_d_oe, 1'b0);
  endtask

  task automatic run_hit(input vec_t v);
    int t0;
    start_cycle(v);
    wait_req();
    if (!loc_req) return;
    chk("loc_we", loc_we, !v.rw);
    chk("loc_be", loc_be, v.be);
    chk("loc_addr", loc_addr, v.laddr);
    if (!v.rw) chk("loc_wdata", loc_wdata, v.wdata);
    repeat (v.ack_dly) @(negedge c200m);
    chk("req_held", {loc_req, dtack_oe}, 2'b10);
    ack_pulse(v.rdata);
    chk("req_drop", loc_req, 1'b0);
    if (v.rw) begin
      chk("doe_after_ack", {m68k_d_oe, dtack_oe}, 2'b10);
      t0 = cyc;
      wait_dtack();
      chk("dtack_lead", cyc - t0, 4);
      chk("d_out", m68k_d_out, v.rdata);
    end else begin
      chk("dtack_after_ack", {dtack_oe, m68k_d_oe}, 2'b10);
    end
    release_bus();
  endtask

  task automatic run_miss(input vec_t v);
    logic any = 1'b0;
    start_cycle(v);
    repeat (40) begin
      @(negedge c200m);
      any |= loc_req | dtack_oe | m68k_d_oe;
    end
    chk("miss_quiet", any, 1'b0);
    release_bus();
  endtask

  initial begin
    logic any;
    int   t0;
    //          rw    byte addr     ds_n   wdata     dly rdata     hit   be     loc_addr
    vecs[0] = '{1'b1, 24'h200010, 2'b00, 16'h0000, 3, 16'hBEEF, 1'b1, 2'b11, 23'h100008};
    vecs[1] = '{1'b0, 24'h3FFFFE, 2'b10, 16'h00A5, 2, 16'h0000, 1'b1, 2'b01, 23'h1FFFFF};
    vecs[2] = '{1'b1, 24'h400000, 2'b00, 16'h0000, 0, 16'h0000, 1'b0, 2'b00, 23'h000000};
    vecs[3] = '{1'b0, 24'h200100, 2'b01, 16'h1234, 0, 16'h0000, 1'b1, 2'b10, 23'h100080};
    vecs[4] = '{1'b1, 24'h3FFFFE, 2'b01, 16'h0000, 7, 16'h5A5A, 1'b1, 2'b10, 23'h1FFFFF};
    vecs[5] = '{1'b1, 24'h1FFFFE, 2'b00, 16'h0000, 0, 16'h0000, 1'b0, 2'b00, 23'h000000};
    vecs[6] = '{1'b0, 24'h600000, 2'b00, 16'hFFFF, 0, 16'h0000, 1'b0, 2'b00, 23'h000000};

    repeat (3) @(negedge c200m);
    chk("reset_outputs", {m68k_d_out, m68k_d_oe, dtack_oe, berr_oe, loc_req}, '0);
    rst = 1'b0;
    repeat (2) @(negedge c200m);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].hit) run_hit(vecs[i]);
      else run_miss(vecs[i]);
      $display("txn %0d rw=%0b addr=%06h hit=%0b errors=%0d", i, vecs[i].rw, vecs[i].baddr,
               vecs[i].hit, errors);
    end

    // Abort: AS pulses without any data strobe, then a normal cycle.
    @(negedge c200m);
    m68k_addr = 23'h100000;
    m68k_rw   = 1'b1;
    m68k_as_n = 1'b0;
    any = 1'b0;
    repeat (20) begin @(negedge c200m); any |= loc_req; end
    m68k_as_n = 1'b1;
    repeat (5) begin @(negedge c200m); any |= loc_req; end
    chk("abort_no_req", any, 1'b0);
    run_hit(vecs[0]);
    $display("txn abort errors=%0d", errors);

    // AS released while the local request is pending: completes, never acknowledged on the bus.
    start_cycle(vecs[0]);
    wait_req();
    @(negedge c200m);
    m68k_as_n = 1'b1;
    {m68k_uds_n, m68k_lds_n} = 2'b11;
    repeat (5) @(negedge c200m);
    chk("req_no_retract", loc_req, 1'b1);
    ack_pulse(16'h1111);
    chk("req_drop_late", loc_req, 1'b0);
    any = 1'b0;
    repeat (20) begin @(negedge c200m); any |= dtack_oe | m68k_d_oe; end
    chk("as_rise_no_dtack", any, 1'b0);
    $display("txn as_rise errors=%0d", errors);

    // Local side never acknowledges.
    start_cycle(vecs[0]);
    wait_req();
`ifdef M68K_TARGET_BERR_EN
    t0 = cyc;
    for (int i = 0; i < 400; i++) begin
      if (berr_oe) break;
      @(negedge c200m);
    end
    chk("berr_delay", cyc - t0, 255);
    chk("berr_req_drop", {loc_req, dtack_oe}, 2'b00);
    ack_pulse(16'h2222);
    @(negedge c200m);
    chk("berr_late_ack", {berr_oe, dtack_oe, m68k_d_oe}, 3'b100);
    release_bus();
    chk("berr_release", berr_oe, 1'b0);
`else
    any = 1'b0;
    repeat (300) begin @(negedge c200m); any |= berr_oe; end
    chk("no_timeout_req", loc_req, 1'b1);
    chk("no_timeout_berr", any, 1'b0);
    ack_pulse(16'h3333);
    wait_dtack();
    chk("late_ack_dtack", dtack_oe, 1'b1);
    chk("late_ack_dout", m68k_d_out, 16'h3333);
    release_bus();
`endif
    $display("txn timeout errors=%0d", errors);

    // Reset while DTACK is driven.
    start_cycle(vecs[4]);
    wait_req();
    ack_pulse(16'hC0DE);
    wait_dtack();
    chk("pre_reset_dtack", dtack_oe, 1'b1);
    rst = 1'b1;
    m68k_as_n = 1'b1;
    {m68k_uds_n, m68k_lds_n} = 2'b11;
    @(negedge c200m);
    chk("reset_mid_ack", {m68k_d_out, m68k_d_oe, dtack_oe, berr_oe, loc_req}, '0);
    rst = 1'b0;
    repeat (2) @(negedge c200m);
    run_hit(vecs[3]);
    $display("txn reset_mid_ack errors=%0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
